// File: rtl/wireframe_sequencer_if.sv
// rtl/wireframe_sequencer_if.sv - signal bundle between command source, line drawer, framebuffer and the sequencer
// Purpose: groups the triangle command handshake, the line-drawer start/done
// handshake, the drawer write stream, the framebuffer write port and status.
// Modports:
//   slave  - the sequencer: consumes tri_*, clear_req, line_done, drw_*;
//            drives tri_ready, line_*, line_start, fb_*, busy, frame_done, err_timeout.
//   master - the surrounding system (command source, drawer, framebuffer).
interface wireframe_sequencer_if;
    logic        tri_valid;
    logic        tri_ready;
    logic [7:0]  tri_x0;
    logic [7:0]  tri_y0;
    logic [7:0]  tri_x1;
    logic [7:0]  tri_y1;
    logic [7:0]  tri_x2;
    logic [7:0]  tri_y2;
    logic        clear_req;
    logic [7:0]  line_x0;
    logic [7:0]  line_y0;
    logic [7:0]  line_x1;
    logic [7:0]  line_y1;
    logic        line_start;
    logic        line_done;
    logic [15:0] drw_fb_addr;
    logic [7:0]  drw_fb_data;
    logic        drw_w_en;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_w_en;
    logic        busy;
    logic        frame_done;
    logic        err_timeout;

    modport slave (
        input  tri_valid, tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2,
        input  clear_req, line_done, drw_fb_addr, drw_fb_data, drw_w_en,
        output tri_ready, line_x0, line_y0, line_x1, line_y1, line_start,
        output fb_addr, fb_data, fb_w_en, busy, frame_done, err_timeout
    );

    modport master (
        output tri_valid, tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2,
        output clear_req, line_done, drw_fb_addr, drw_fb_data, drw_w_en,
        input  tri_ready, line_x0, line_y0, line_x1, line_y1, line_start,
        input  fb_addr, fb_data, fb_w_en, busy, frame_done, err_timeout
    );
endinterface

// File: rtl/wireframe_sequencer.sv
// rtl/wireframe_sequencer.sv - triangle-to-edge sequencer with framebuffer clear sweep and edge watchdog
// Purpose: accepts one triangle, issues its three edges to the line drawer
// (skipping zero-length edges), aborts an edge whose drawer never answers,
// and owns the framebuffer write port (drawer pass-through or clear sweep).
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - wireframe_sequencer_if.slave (command, drawer, framebuffer, status)
// Parameters:
//   CLEAR_COLOR - pixel value written by the clear sweep
//   TIMEOUT     - cycles allowed from line_start to line_done (2..65535)
module wireframe_sequencer #(
    parameter logic [7:0] CLEAR_COLOR = 8'h00,
    parameter int         TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wireframe_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  vx_q [3];
    logic [7:0]  vx_d [3];
    logic [7:0]  vy_q [3];
    logic [7:0]  vy_d [3];
    logic [1:0]  edge_q, edge_d;
    logic [15:0] wd_q, wd_d;
    logic [15:0] sweep_q, sweep_d;
    logic        pend_q, pend_d;
    logic [7:0]  line_x0_q, line_x0_d;
    logic [7:0]  line_y0_q, line_y0_d;
    logic [7:0]  line_x1_q, line_x1_d;
    logic [7:0]  line_y1_q, line_y1_d;
    logic        line_start_q, line_start_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;

    logic        load;
    logic [1:0]  load_edge;
    logic [1:0]  ea, eb;

    function automatic logic [7:0] pick(input logic [1:0] i, input logic [7:0] v0,
                                        input logic [7:0] v1, input logic [7:0] v2);
        case (i)
            2'd0:    pick = v0;
            2'd1:    pick = v1;
            default: pick = v2;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        edge_d       = edge_q;
        wd_d         = wd_q;
        sweep_d      = sweep_q;
        pend_d       = pend_q;
        line_x0_d    = line_x0_q;
        line_y0_d    = line_y0_q;
        line_x1_d    = line_x1_q;
        line_y1_d    = line_y1_q;
        line_start_d = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        load         = 1'b0;
        load_edge    = edge_q;

        case (state_q)
            S_IDLE: begin
                // A fresh or pending clear always wins over a waiting triangle.
                if (bus.clear_req || pend_q) begin
                    state_d = S_CLEAR;
                    sweep_d = 16'h0000;
                    pend_d  = 1'b0;
                end else if (bus.tri_valid) begin
                    vx_d      = '{bus.tri_x0, bus.tri_x1, bus.tri_x2};
                    vy_d      = '{bus.tri_y0, bus.tri_y1, bus.tri_y2};
                    edge_d    = 2'd0;
                    load      = 1'b1;
                    load_edge = 2'd0;
                    state_d   = S_ISSUE;
                end
            end
            S_CLEAR: begin
                if (sweep_q == 16'hFFFF) begin
                    state_d      = S_FINISH;
                    frame_done_d = 1'b1;
                end else begin
                    sweep_d = sweep_q + 16'd1;
                end
            end
            S_ISSUE: begin
                // line_start_q is high exactly when this ISSUE cycle carries a
                // real edge; otherwise the edge was zero-length and is skipped.
                if (line_start_q) begin
                    state_d = S_WAIT;
                    wd_d    = 16'h0000;
                end else if (edge_q == 2'd2) begin
                    state_d      = S_FINISH;
                    frame_done_d = 1'b1;
                end else begin
                    edge_d    = edge_q + 2'd1;
                    load      = 1'b1;
                    load_edge = edge_q + 2'd1;
                end
            end
            S_WAIT: begin
                if (bus.line_done) begin
                    if (edge_q == 2'd2) begin
                        state_d      = S_FINISH;
                        frame_done_d = 1'b1;
                    end else begin
                        edge_d    = edge_q + 2'd1;
                        load      = 1'b1;
                        load_edge = edge_q + 2'd1;
                        state_d   = S_ISSUE;
                    end
                end else if (wd_q == WD_LAST) begin
                    err_d        = 1'b1;
                    state_d      = S_FINISH;
                    frame_done_d = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clears requested while drawing are remembered; during a sweep they are redundant.
        if (bus.clear_req && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_FINISH)) begin
            pend_d = 1'b1;
        end

        // Edge e runs from vertex e to vertex (e+1) mod 3.
        ea = load_edge;
        eb = (load_edge == 2'd2) ? 2'd0 : load_edge + 2'd1;
        if (load) begin
            line_x0_d    = pick(ea, vx_d[0], vx_d[1], vx_d[2]);
            line_y0_d    = pick(ea, vy_d[0], vy_d[1], vy_d[2]);
            line_x1_d    = pick(eb, vx_d[0], vx_d[1], vx_d[2]);
            line_y1_d    = pick(eb, vy_d[0], vy_d[1], vy_d[2]);
            line_start_d = (line_x0_d != line_x1_d) || (line_y0_d != line_y1_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vx_q         <= '{default: 8'h00};
            vy_q         <= '{default: 8'h00};
            edge_q       <= 2'd0;
            wd_q         <= 16'h0000;
            sweep_q      <= 16'h0000;
            pend_q       <= 1'b0;
            line_x0_q    <= 8'h00;
            line_y0_q    <= 8'h00;
            line_x1_q    <= 8'h00;
            line_y1_q    <= 8'h00;
            line_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            edge_q       <= edge_d;
            wd_q         <= wd_d;
            sweep_q      <= sweep_d;
            pend_q       <= pend_d;
            line_x0_q    <= line_x0_d;
            line_y0_q    <= line_y0_d;
            line_x1_q    <= line_x1_d;
            line_y1_q    <= line_y1_d;
            line_start_q <= line_start_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Outputs are forced low while reset is asserted, so the framebuffer port
    // stops writing the instant reset arrives even mid-sweep.
    assign bus.tri_ready   = rst_n && (state_q == S_IDLE) && !bus.clear_req && !pend_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.line_x0     = line_x0_q;
    assign bus.line_y0     = line_y0_q;
    assign bus.line_x1     = line_x1_q;
    assign bus.line_y1     = line_y1_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err_timeout = err_q;

    assign bus.fb_w_en = !rst_n ? 1'b0  : (state_q == S_CLEAR) ? 1'b1        : bus.drw_w_en;
    assign bus.fb_addr = !rst_n ? 16'h0 : (state_q == S_CLEAR) ? sweep_q     : bus.drw_fb_addr;
    assign bus.fb_data = !rst_n ? 8'h00 : (state_q == S_CLEAR) ? CLEAR_COLOR : bus.drw_fb_data;

endmodule

// File: doc/wireframe_sequencer.md
# wireframe_sequencer

Controller that sits between the command source (PS/AXI register block) and the Bresenham line drawer. It accepts one triangle at a time, breaks it into three edge jobs, and issues them to the line drawer with a start/done handshake. It also owns the framebuffer write port: it muxes the drawer's write stream with its own screen-clear sweep. A per-edge watchdog ensures a hung drawer cannot stall the pipeline.

## Interface
Parameters:
- CLEAR_COLOR, 8'h00: pixel value written by the clear sweep.
- TIMEOUT, 1024: maximum cycles from line_start to line_done before the edge is aborted (2..65535).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tri_valid  in  1  triangle command valid.
- tri_ready  out  1  sequencer can accept a triangle.
- tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2  in  8 each  vertex coordinates, captured on the tri_valid & tri_ready cycle.
- clear_req  in  1  single-cycle request to clear the whole framebuffer.
- line_x0, line_y0, line_x1, line_y1  out  8 each  endpoints for the current edge; registered and held stable from line_start until line_done.
- line_start  out  1  one-cycle pulse to the line drawer.
- line_done  in  1  one-cycle pulse from the drawer when the edge is finished.
- drw_fb_addr  in  16  drawer write address ({x,y}).
- drw_fb_data  in  8  drawer pixel.
- drw_w_en  in  1  drawer write enable.
- fb_addr  out  16  framebuffer write address.
- fb_data  out  8  framebuffer write data.
- fb_w_en  out  1  framebuffer write enable.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last edge of a triangle, or after the clear sweep completes.
- err_timeout  out  1  sticky flag, set on any watchdog abort; cleared only by reset.

## Operation
- States: IDLE, CLEAR, ISSUE, WAIT, FINISH.
- IDLE: tri_ready=1 only when clear_req=0 and no clear is pending. clear_req has priority: if clear_req and tri_valid are both high, go to CLEAR and do not accept the triangle. A clear_req arriving in any other state sets a pending bit. The pending clear is serviced on the next return to IDLE, before any new triangle.
- On triangle accept: latch the six coordinates, set edge index e=0, go to ISSUE.
- Edge endpoints: e=0 is (v0,v1), e=1 is (v1,v2), e=2 is (v2,v0).
- ISSUE: load line_* with the endpoints for edge e.
  - Zero-length edge (x0==x1 and y0==y1): skip it. No line_start is issued; advance e, or go to FINISH if e==2.
  - Otherwise: pulse line_start for one cycle, clear the watchdog counter, go to WAIT.
- WAIT: the watchdog increments every cycle.
  - line_done: if e<2, increment e and go to ISSUE; if e==2, go to FINISH.
  - Watchdog reaches TIMEOUT-1 with no line_done: set err_timeout and abandon the rest of the triangle (go to FINISH).
  - line_done and timeout in the same cycle: line_done wins.
- FINISH: pulse frame_done for one cycle, go to IDLE.
- CLEAR: a 16-bit counter sweeps 0x0000 to 0xFFFF, one write per cycle, with fb_data=CLEAR_COLOR. After 0xFFFF, go to FINISH. The counter does not wrap or re-run. A clear_req received during CLEAR is dropped (it does not set pending).
- Write mux: in CLEAR, fb_* come from the sweep and drw_* is ignored. In all other states, fb_* are combinational pass-through of drw_*.

## Timing
- Reset values: tri_ready=0 during reset, 1 in the first cycle after reset release. line_start=0, line_*=0, fb_addr=0, fb_data=0, fb_w_en=0, busy=0, frame_done=0, err_timeout=0. State=IDLE, pending clear=0.
- Triangle accept to first line_start: 1 cycle. Accept happens on edge N; line_start is high in cycle N+1.
- line_done to next line_start: 1 cycle (WAIT→ISSUE→pulse).
- A skipped edge costs 1 cycle in ISSUE.
- Last line_done to frame_done: frame_done is high in the following cycle. tri_ready returns the cycle after that.
- Clear sweep: fb_w_en is high for exactly 65536 consecutive cycles. The first write (addr 0) is in the cycle after the clear_req edge. frame_done is high the cycle after addr 0xFFFF.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). No further line_start is issued, and in-flight edges are abandoned.

## Test plan
- Triangle (10,10),(50,10),(30,40) with the drawer model answering line_done 20 cycles after each start → three line_start pulses with endpoints (10,10→50,10), (50,10→30,40), (30,40→10,10); one frame_done; err_timeout=0.
- Triangle with v0==v1=(5,5), v2=(9,9) → only two line_start pulses (edges 1 and 2); frame_done fires.
- clear_req and tri_valid asserted in the same IDLE cycle → 65536 writes of CLEAR_COLOR covering addr 0x0000..0xFFFF; triangle not accepted; tri_ready high after frame_done.
- TIMEOUT=16, drawer never returns line_done → edge 0 aborted after 16 cycles; err_timeout=1 and stays 1; only one line_start; frame_done pulses.
- clear_req pulsed during WAIT of edge 1 → triangle completes, then the clear sweep starts immediately; tri_valid held high is not accepted until the clear finishes.
- rst_n asserted mid-clear at addr 0x1234 → fb_w_en drops asynchronously; after release busy=0, no pending clear, next triangle accepted normally.
